// File: rtl/serial_tx.sv
// serial_tx: FIFO-buffered UART transmitter (8 data bits, LSB first, one stop bit).
// Define SERIAL_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module serial_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_serial,
    input  logic       i_serial_v,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam logic [15:0]        BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   DEPTH_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   ONE_CNT    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] ONE_PTR    = FIFO_AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               overflow_q, overflow_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];

`ifdef SERIAL_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic       fifo_empty;
    logic       fifo_full;
    logic       bit_done;
    logic       pop;
    logic       push_ok;
    logic [7:0] rd_data;

    // FSM: next state, bit timing and the registered line value for the next cycle
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_CNT);
        bit_done   = (cnt_q == 16'd0);
        rd_data    = mem_q[rd_ptr_q];

        state_d   = state_q;
        cnt_d     = bit_done ? cnt_q : cnt_q - 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                pop  = !fifo_empty;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    cnt_d   = BIT_RELOAD;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    // back-to-back frames: go straight to START when more data is queued
                    pop     = !fifo_empty;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            state_d = START;
            cnt_d   = BIT_RELOAD;
            shift_d = rd_data;
            tx_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = ^rd_data;
`endif
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees a slot this cycle
    always_comb begin
        push_ok    = i_serial_v && (!fifo_full || pop);
        overflow_d = overflow_q || (i_serial_v && !push_ok);
        wr_ptr_d   = push_ok ? wr_ptr_q + ONE_PTR : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + ONE_PTR : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + ONE_CNT;
        end else if (pop && !push_ok) begin
            count_d = count_q - ONE_CNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_serial;
        end
    end

    assign o_tx       = tx_q;
    assign o_busy     = (state_q != IDLE) || !fifo_empty;
    assign o_full     = fifo_full;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed and random stimulus for serial_tx, checked every cycle against
// a frame-timeline reference model (byte queue plus per-frame bit vector).
module tb_serial_tx;

    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_LEN = NBITS * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] i_serial;
    logic       i_serial_v;
    logic       o_tx;
    logic       o_busy;
    logic       o_full;
    logic       o_overflow;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic       m_bits [0:10];
    logic       m_active;
    int         m_pos;
    logic       m_ovf;

    serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_serial   (i_serial),
        .i_serial_v (i_serial_v),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_ovf    = 1'b0;
    endfunction

    // One clock edge of the line: advance the current frame, start the next queued byte
    // when the line is free, then queue any push that still fits.
    function automatic void model_edge(input logic v, input logic [7:0] d);
        logic [7:0] b;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_active) begin
            m_pos++;
            if (m_pos == FRAME_LEN) m_active = 1'b0;
        end
        if (!m_active && m_q.size() > 0) begin
            b = m_q.pop_front();
            m_bits[0] = 1'b0;
            for (int j = 0; j < 8; j++) m_bits[j + 1] = b[j];
            m_bits[9]  = 1'b1;
            m_bits[10] = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            m_bits[9] = ^b;
`endif
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (v) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic apply_stimulus(input logic v, input logic [7:0] d);
        logic exp_tx;
        @(negedge clk);
        i_serial_v = v;
        i_serial   = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        exp_tx = m_active ? m_bits[m_pos / CPB] : 1'b1;
        check_output("tx", 32'(o_tx), 32'(exp_tx));
        check_output("busy", 32'(o_busy), 32'(m_active || m_q.size() > 0));
        check_output("full", 32'(o_full), 32'(m_q.size() == DEPTH));
        check_output("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        i_serial_v = 1'b0;
        model_reset();
        #1;
        check_output("rst_tx", 32'(o_tx), 32'd1);
        check_output("rst_busy", 32'(o_busy), 32'd0);
        repeat (2) apply_stimulus(1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && (m_active || m_q.size() > 0); i++) apply_stimulus(1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00);
        check_output(tag, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int busy_cycles;
        logic parity_seen;
        rst        = 1'b0;
        i_serial   = 8'h00;
        i_serial_v = 1'b0;
        model_reset();
        do_reset();
        check_output("reset_full", 32'(o_full), 32'd0);
        check_output("reset_ovf", 32'(o_overflow), 32'd0);

        // single 0x55 frame: start bit appears two cycles after the push
        apply_stimulus(1'b1, 8'h55);
        check_output("x55_still_idle", 32'(o_tx), 32'd1);
        apply_stimulus(1'b0, 8'h00);
        check_output("x55_start", 32'(o_tx), 32'd0);
        drain("x55_busy_done");

        // 0x07 frame length and parity slot
        busy_cycles = 0;
        parity_seen = 1'b0;
        apply_stimulus(1'b1, 8'h07);
        if (o_busy) busy_cycles++;
        for (int i = 1; i < 100; i++) begin
            apply_stimulus(1'b0, 8'h00);
            if (i - 1 == 9 * CPB + 1) parity_seen = o_tx;
            if (!o_busy) break;
            busy_cycles++;
        end
        check_output("x07_frame_len", 32'(busy_cycles), 32'(1 + FRAME_LEN));
        check_output("x07_bit9", 32'(parity_seen), 32'd1);
        drain("x07_done");

        // push during the stop bit: next start bit follows with no gap
        apply_stimulus(1'b1, 8'h3C);
        repeat (1 + (NBITS - 1) * CPB) apply_stimulus(1'b0, 8'h00);
        apply_stimulus(1'b1, 8'h07);
        repeat (CPB - 1) apply_stimulus(1'b0, 8'h00);
        check_output("b2b_start", 32'(o_tx), 32'd0);
        drain("b2b_done");

        // 16 pushes on alternate cycles
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 8'(i));
            apply_stimulus(1'b0, 8'h00);
        end
        drain("alt16_done");
        check_output("alt16_ovf", 32'(o_overflow), 32'd0);

        // 18 consecutive pushes: 17th fills the FIFO, 18th is dropped
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(1'b1, 8'(8'hA0 + i));
            if (i == 16) check_output("burst_full17", 32'(o_full), 32'd1);
            if (i == 16) check_output("burst_ovf17", 32'(o_overflow), 32'd0);
        end
        check_output("burst_ovf18", 32'(o_overflow), 32'd1);
        drain("burst_done");
        check_output("burst_ovf_sticky", 32'(o_overflow), 32'd1);
        do_reset();

        // reset during data bit 3 of 0xA5 (that bit is 0 on the line)
        apply_stimulus(1'b1, 8'hA5);
        repeat (1 + 4 * CPB + 1) apply_stimulus(1'b0, 8'h00);
        check_output("a5_bit3_low", 32'(o_tx), 32'd0);
        rst = 1'b1;
        model_reset();
        #1;
        check_output("abort_tx", 32'(o_tx), 32'd1);
        check_output("abort_busy", 32'(o_busy), 32'd0);
        check_output("abort_full", 32'(o_full), 32'd0);
        repeat (2) apply_stimulus(1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) apply_stimulus(1'b0, 8'h00);
        check_output("abort_quiet", 32'(o_tx), 32'd1);

        // randomized traffic with periodic dense bursts
        for (int i = 0; i < 1200; i++) begin
            if ((i % 300) < 40) apply_stimulus(1'($urandom_range(0, 3) != 0), 8'($urandom));
            else apply_stimulus(1'($urandom_range(0, 29) == 0), 8'($urandom));
        end
        drain("random_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, meaning clk cycles per UART bit period (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_AW, default 4, meaning log2 of FIFO depth (depth = 16 at default).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_serial  input  8  byte to transmit (the termbuffer o_serial stream).
REQ-006 SHALL have port i_serial_v  input  1  single-cycle push strobe for i_serial.
REQ-007 SHALL have port o_tx  output  1  UART line, idle high.
REQ-008 SHALL have port o_busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-009 SHALL have port o_full  output  1  high when FIFO count equals depth.
REQ-010 SHALL have port o_overflow  output  1  sticky; set when a push is dropped.

Function
REQ-011 SHALL buffer bytes in a FIFO of 2**FIFO_AW entries; push when i_serial_v is high.
REQ-012 SHALL accept a push when count < depth, or when count == depth and a pop occurs in the same cycle.
REQ-013 SHALL drop a rejected push, leave FIFO contents unchanged, and set o_overflow until reset.
REQ-014 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL, in IDLE with FIFO non-empty, pop one byte into a shift register and go to START.
REQ-016 SHALL drive o_tx from a register; o_tx goes low for the start bit 2 cycles after the i_serial_v that was sampled into an empty FIFO while idle.
REQ-017 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a down-counter reloaded at every bit boundary.
REQ-018 SHALL send 8 data bits LSB first in DATA, using a 3-bit index that must not wrap past bit 7.
REQ-019 SHALL send one stop bit (o_tx = 1) in STOP.
REQ-020 SHALL, at the end of STOP, pop the next byte and enter START directly when the FIFO is non-empty, with no idle bit between frames; otherwise it SHALL return to IDLE.
REQ-021 SHALL keep o_tx high whenever in IDLE.
REQ-022 SHALL ignore pushes only when full; a push arriving during any FSM state is queued.
REQ-023 SHALL deassert o_busy in the first cycle after the stop bit of the last queued byte completes.

Reset
REQ-024 SHALL, while rst is high, immediately force o_tx=1, o_busy=0, o_full=0, o_overflow=0, FIFO pointers and count=0, bit counter=0, FSM=IDLE.
REQ-025 SHALL abort any frame in progress on reset; no partial frame resumes after reset is released.

Configuration
REQ-026 SHALL, with SERIAL_TX_PARITY_EN defined, insert the PARITY state between DATA and STOP and send an even-parity bit (XOR of the 8 data bits), giving an 11-bit frame.
REQ-027 SHALL, without SERIAL_TX_PARITY_EN, skip the PARITY state entirely and send a 10-bit frame.

Verification (CLKS_PER_BIT=4, FIFO_AW=4)
REQ-028 SHALL cover a single push of 0x55 while idle -> o_tx low 2 cycles later for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles (40-cycle frame); o_busy low afterwards.
REQ-029 SHALL cover 16 pushes 0x00..0x0F on alternate cycles -> all 16 frames out in order, back-to-back with no idle gaps, o_overflow=0.
REQ-030 SHALL cover 18 pushes on consecutive cycles from empty -> the first 17 are transmitted, the 18th is dropped, o_full=1 at the 17th push, o_overflow=1 and holds.
REQ-031 SHALL cover rst asserted during data bit 3 of 0xA5 -> o_tx=1 in the same cycle, o_busy=0, and no further line activity after reset is released.
REQ-032 SHALL cover a push of 0x07 during the stop bit of the previous frame -> the new start bit immediately follows that stop bit.
REQ-033 SHALL cover 0x07 with SERIAL_TX_PARITY_EN defined -> parity bit 1 and a 44-cycle frame; without the macro -> a 40-cycle frame.
